// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: instruction classes,
// result-ready stage lookup and forward-select width.
package pipe_hazard_unit_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_NONE = 2'd3
  } cls_e;

  localparam int SHADOW_W = 3;

  function automatic int sel_w(input int nstg);
    return $clog2(nstg + 1);
  endfunction

  // Stage at whose output bus the result first appears.
  function automatic int cls_rstg(input logic [1:0] cls, input int mul_stg);
    case (cls)
      CLS_LOAD: return 2;
      CLS_MUL:  return mul_stg;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request / hazard-decision bundle between the decoder and the hazard unit.
interface pipe_hazard_unit_if
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RAW = 5,
  parameter int SW  = 2,
  parameter int PCW = 16
);
  logic           id_valid;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic           id_use_rs;
  logic           id_use_rt;
  logic           id_rt_late;
  logic           id_wreg;
  logic [RAW-1:0] id_rd;
  logic [1:0]     id_cls;
  logic           flush;
  logic           stall;
  logic           issue;
  logic           squash;
  logic [SW-1:0]  fwd_a;
  logic [SW-1:0]  fwd_b;
  logic           late_b;
  logic [SW-1:0]  late_b_sel;
  logic [PCW-1:0] perf_stall;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rt_late,
           id_wreg, id_rd, id_cls, flush,
    input  stall, issue, squash, fwd_a, fwd_b, late_b, late_b_sel, perf_stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rt_late,
           id_wreg, id_rd, id_cls, flush,
    output stall, issue, squash, fwd_a, fwd_b, late_b, late_b_sel, perf_stall
  );
endinterface

// File: rtl/pipe_hazard_unit_sb_entry_match.sv
// One scoreboard slot comparator: matches the slot's destination against both
// ID source operands and reports whether its result is ready at this stage.
module sb_entry_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RAW = 5,
  parameter int SW  = 2,
  parameter int K   = 1
) (
  input  logic           vld_i,
  input  logic [RAW-1:0] rd_i,
  input  logic [SW-1:0]  rstg_i,
  input  logic [RAW-1:0] rs_i,
  input  logic [RAW-1:0] rt_i,
  input  logic           use_rs_i,
  input  logic           use_rt_i,
  output logic           hit_rs_o,
  output logic           hit_rt_o,
  output logic           rdy_o,
  output logic           rdy_late_o
);
  localparam logic [SW-1:0] KS = SW'(K);
  localparam logic [SW:0]   KL = (SW+1)'(K + 1);

  assign hit_rs_o   = vld_i & use_rs_i & (rs_i != '0) & (rd_i == rs_i);
  assign hit_rt_o   = vld_i & use_rt_i & (rt_i != '0) & (rd_i == rt_i);
  assign rdy_o      = (KS >= rstg_i);
  // Ready one cycle later: enough for store data consumed in the next stage.
  assign rdy_late_o = (KL >= {1'b0, rstg_i});
endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based ID hazard controller: stall, operand forwarding, late store
// data forwarding and branch-shadow squash for the in-order pipeline.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int NSTG      = 3,
  parameter int RAW       = 5,
  parameter int MUL_STG   = 3,
  parameter int BR_SHADOW = 1,
  parameter int PCW       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_unit_if.slave hz
);
  localparam int SW = sel_w(NSTG);

  logic [NSTG:1]     vld_q;
  logic [NSTG:1]     mul_q;
  logic [RAW-1:0]    rd_q   [1:NSTG];
  logic [SW-1:0]     rstg_q [1:NSTG];
  logic [SHADOW_W-1:0] shd_q, shd_d;
  logic [PCW-1:0]    perf_q, perf_d;

  logic              ent_vld_d, ent_mul_d;
  logic [SW-1:0]     ent_rstg_d;

  logic hit_rs   [1:NSTG];
  logic hit_rt   [1:NSTG];
  logic rdy      [1:NSTG];
  logic rdy_late [1:NSTG];

  logic          hit_a, rdy_a, hit_b, rdy_b, rdyl_b;
  logic [SW-1:0] ka, kb;
  logic          stall_a, stall_b, stall_s, mul_busy;
  logic          squash_w, stall_w, issue_w, late_w;
  logic [SW-1:0] fwd_a_w, fwd_b_w, late_sel_w;

  for (genvar g = 1; g <= NSTG; g++) begin : g_ent
    sb_entry_match #(.RAW(RAW), .SW(SW), .K(g)) u_match (
      .vld_i      (vld_q[g]),
      .rd_i       (rd_q[g]),
      .rstg_i     (rstg_q[g]),
      .rs_i       (hz.id_rs),
      .rt_i       (hz.id_rt),
      .use_rs_i   (hz.id_use_rs),
      .use_rt_i   (hz.id_use_rt),
      .hit_rs_o   (hit_rs[g]),
      .hit_rt_o   (hit_rt[g]),
      .rdy_o      (rdy[g]),
      .rdy_late_o (rdy_late[g])
    );
  end

  // Youngest producer wins: scan oldest to youngest, later hits overwrite.
  always_comb begin
    hit_a  = 1'b0;
    rdy_a  = 1'b0;
    ka     = '0;
    hit_b  = 1'b0;
    rdy_b  = 1'b0;
    rdyl_b = 1'b0;
    kb     = '0;
    for (int k = NSTG; k >= 1; k--) begin
      if (hit_rs[k]) begin
        hit_a = 1'b1;
        rdy_a = rdy[k];
        ka    = SW'(k);
      end
      if (hit_rt[k]) begin
        hit_b  = 1'b1;
        rdy_b  = rdy[k];
        rdyl_b = rdy_late[k];
        kb     = SW'(k);
      end
    end
  end

  always_comb begin
    fwd_a_w    = (hit_a & rdy_a) ? ka : '0;
    stall_a    = hit_a & ~rdy_a;
    fwd_b_w    = '0;
    late_w     = 1'b0;
    late_sel_w = '0;
    stall_b    = 1'b0;
    if (hit_b) begin
      if (rdy_b) begin
        fwd_b_w = kb;
      end else if (hz.id_rt_late & rdyl_b) begin
        late_w     = 1'b1;
        late_sel_w = kb + SW'(1);
      end else begin
        stall_b = 1'b1;
      end
    end
    // The multiplier is not pipelined: a younger MUL must wait for it to drain.
    mul_busy = 1'b0;
    for (int k = 1; k <= NSTG; k++) begin
      if ((k < MUL_STG - 1) && vld_q[k] && mul_q[k]) mul_busy = 1'b1;
    end
    stall_s  = (hz.id_cls == CLS_MUL) & mul_busy;
    squash_w = hz.flush | (shd_q != '0);
    stall_w  = (stall_a | stall_b | stall_s) & ~squash_w & hz.id_valid;
    issue_w  = hz.id_valid & ~stall_w & ~squash_w;
  end

  assign ent_vld_d  = issue_w & hz.id_wreg & (hz.id_rd != '0);
  assign ent_mul_d  = (hz.id_cls == CLS_MUL);
  assign ent_rstg_d = SW'(cls_rstg(hz.id_cls, MUL_STG));

  assign shd_d  = hz.flush       ? SHADOW_W'(BR_SHADOW) :
                  (shd_q != '0)  ? shd_q - SHADOW_W'(1) : shd_q;
  assign perf_d = (stall_w && (perf_q != '1)) ? perf_q + PCW'(1) : perf_q;

  // ID -> stage 1 boundary; older entries advance one stage per clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mul_q  <= '0;
      shd_q  <= '0;
      perf_q <= '0;
    end else begin
      vld_q  <= {vld_q[NSTG-1:1], ent_vld_d};
      mul_q  <= {mul_q[NSTG-1:1], ent_mul_d};
      shd_q  <= shd_d;
      perf_q <= perf_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q[1]   <= hz.id_rd;
    rstg_q[1] <= ent_rstg_d;
    for (int k = 2; k <= NSTG; k++) begin
      rd_q[k]   <= rd_q[k-1];
      rstg_q[k] <= rstg_q[k-1];
    end
  end

  assign hz.stall      = stall_w;
  assign hz.issue      = issue_w;
  assign hz.squash     = squash_w;
  assign hz.fwd_a      = fwd_a_w;
  assign hz.fwd_b      = fwd_b_w;
  assign hz.late_b     = late_w;
  assign hz.late_b_sel = late_sel_w;
  assign hz.perf_stall = perf_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed vector table, hand-written
// reset/flush/saturation sequences, then random traffic against a reference model.
module tb_pipe_hazard_unit;
  import pipe_hazard_unit_pkg::*;

  localparam int NSTG = 3, RAW = 5, MUL_STG = 3, BR_SHADOW = 1, PCW = 4;
  localparam int SW = sel_w(NSTG);
  localparam int PMAX = (1 << PCW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.RAW(RAW), .SW(SW), .PCW(PCW)) hz ();

  pipe_hazard_unit #(.NSTG(NSTG), .RAW(RAW), .MUL_STG(MUL_STG),
                     .BR_SHADOW(BR_SHADOW), .PCW(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    int v, rs, rt, urs, urt, late, wreg, rd, cls, fl;
    int stall, issue, squash, fa, fb, lb, lsel;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int late,
                              int wreg, int rd, int cls, int fl, int s, int i,
                              int sq, int fa, int fb, int lb, int ls);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.late = late;
    r.wreg = wreg; r.rd = rd; r.cls = cls; r.fl = fl;
    r.stall = s; r.issue = i; r.squash = sq; r.fa = fa; r.fb = fb; r.lb = lb; r.lsel = ls;
    return r;
  endfunction

  task automatic drive(int v, int rs, int rt, int urs, int urt, int late,
                       int wreg, int rd, int cls, int fl);
    hz.id_valid   = 1'(v);
    hz.id_rs      = RAW'(rs);
    hz.id_rt      = RAW'(rt);
    hz.id_use_rs  = 1'(urs);
    hz.id_use_rt  = 1'(urt);
    hz.id_rt_late = 1'(late);
    hz.id_wreg    = 1'(wreg);
    hz.id_rd      = RAW'(rd);
    hz.id_cls     = 2'(cls);
    hz.flush      = 1'(fl);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int s, input int i, input int sq,
                          input int fa, input int fb, input int lb, input int ls);
    chk({tag, ".stall"},      32'(hz.stall),      32'(s));
    chk({tag, ".issue"},      32'(hz.issue),      32'(i));
    chk({tag, ".squash"},     32'(hz.squash),     32'(sq));
    chk({tag, ".fwd_a"},      32'(hz.fwd_a),      32'(fa));
    chk({tag, ".fwd_b"},      32'(hz.fwd_b),      32'(fb));
    chk({tag, ".late_b"},     32'(hz.late_b),     32'(lb));
    chk({tag, ".late_b_sel"}, 32'(hz.late_b_sel), 32'(ls));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // hist[i] is the instruction issued i+1 cycles ago (so it sits in stage i+1).
  typedef struct { bit v; int rd; int cls; } fly_t;
  fly_t hist[$];
  int shadow_m, perf_m;
  int e_s, e_i, e_sq, e_fa, e_fb, e_lb, e_ls;

  function automatic int ready_at(int cls);
    if (cls == 1) return 2;
    if (cls == 2) return MUL_STG;
    return 1;
  endfunction

  // Youngest producer of r: its stage and the cycles still to wait for its result.
  function automatic void producer(input int r, input int used, output int k, output int wt);
    k = 0; wt = 0;
    if (used == 0 || r == 0) return;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].rd == r) begin
        k = i + 1; wt = ready_at(hist[i].cls) - k; return;
      end
  endfunction

  function automatic void model_reset();
    fly_t b;
    b.v = 0; b.rd = 0; b.cls = 0;
    hist.delete();
    for (int i = 0; i < NSTG; i++) hist.push_back(b);
    shadow_m = 0; perf_m = 0;
  endfunction

  function automatic void model_eval(int v, int rs, int rt, int urs, int urt, int late,
                                     int cls, int fl);
    int ka, wa, kb, wb;
    bit hold, mulbusy;
    producer(rs, urs, ka, wa);
    producer(rt, urt, kb, wb);
    hold = 0;
    e_fa = 0; e_fb = 0; e_lb = 0; e_ls = 0;
    if (ka != 0) begin
      if (wa <= 0) e_fa = ka; else hold = 1;
    end
    if (kb != 0) begin
      if (wb <= 0) e_fb = kb;
      else if (late != 0 && wb == 1) begin e_lb = 1; e_ls = kb + 1; end
      else hold = 1;
    end
    mulbusy = 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].cls == 2 && (i + 1) < MUL_STG - 1) mulbusy = 1;
    if (cls == 2 && mulbusy) hold = 1;
    e_sq = (fl != 0 || shadow_m > 0) ? 1 : 0;
    e_s  = (hold && e_sq == 0 && v != 0) ? 1 : 0;
    e_i  = (v != 0 && e_s == 0 && e_sq == 0) ? 1 : 0;
  endfunction

  function automatic void model_commit(int rstn, int wreg, int rd, int cls, int fl);
    fly_t n;
    if (rstn == 0) begin model_reset(); return; end
    n.v = (e_i != 0 && wreg != 0 && rd != 0); n.rd = rd; n.cls = cls;
    hist.push_front(n);
    void'(hist.pop_back());
    if (fl != 0) shadow_m = BR_SHADOW;
    else if (shadow_m > 0) shadow_m--;
    if (e_s != 0 && perf_m < PMAX) perf_m++;
  endfunction

  initial begin
    // v  rs rt urs urt late wreg rd cls fl | stall issue squash fa fb lb lsel
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 2, 1, 1, 0, 1, 3, 0, 0,  0, 1, 0, 0, 0, 0, 0); // add r3
    tbl[2]  = mk(1, 3, 0, 1, 0, 0, 1, 7, 0, 0,  0, 1, 0, 1, 0, 0, 0); // use r3 -> fwd 1
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 4, 1, 0,  0, 1, 0, 0, 0, 0, 0); // lw r4
    tbl[4]  = mk(1, 4, 3, 1, 1, 0, 1, 8, 0, 0,  1, 0, 0, 0, 3, 0, 0); // load-use stall
    tbl[5]  = mk(1, 4, 3, 1, 1, 0, 1, 8, 0, 0,  0, 1, 0, 2, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 5, 1, 0,  0, 1, 0, 0, 0, 0, 0); // lw r5
    tbl[7]  = mk(1, 8, 5, 1, 1, 1, 0, 0, 3, 0,  0, 1, 0, 2, 0, 1, 2); // sw late data
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 6, 2, 0,  0, 1, 0, 0, 0, 0, 0); // mul r6
    tbl[9]  = mk(1, 2, 0, 1, 0, 0, 1, 9, 2, 0,  1, 0, 0, 0, 0, 0, 0); // mul r9: structural
    tbl[10] = mk(1, 2, 0, 1, 0, 0, 1, 9, 2, 0,  0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 9, 0, 1, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0); // mul-use
    tbl[12] = mk(1, 9, 0, 1, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 9, 0, 1, 0, 0, 1, 10, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 11, 1, 0, 0, 1, 0, 0, 0, 0, 0); // lw r11
    tbl[15] = mk(1, 11, 0, 1, 0, 0, 1, 12, 0, 1, 0, 0, 1, 0, 0, 0, 0); // flush
    tbl[16] = mk(1, 11, 0, 1, 0, 0, 1, 12, 0, 0, 0, 0, 1, 2, 0, 0, 0); // shadow
    tbl[17] = mk(1, 11, 0, 1, 0, 0, 1, 12, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0); // add r0
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0); // lw r0
    tbl[20] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0); // read r0

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset.perf", 32'(hz.perf_stall), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].late,
            tbl[i].wreg, tbl[i].rd, tbl[i].cls, tbl[i].fl);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i].stall, tbl[i].issue, tbl[i].squash,
               tbl[i].fa, tbl[i].fb, tbl[i].lb, tbl[i].lsel);
      next_cycle();
    end
    chk("vec.perf", 32'(hz.perf_stall), 32'd4);

    // Reset in the middle of a MUL-use stall.
    drive(1, 0, 0, 0, 0, 0, 1, 6, 2, 0);
    @(negedge clk); chk("rstmul.issue_mul", 32'(hz.issue), 32'd1);
    next_cycle();
    drive(1, 6, 0, 1, 0, 0, 1, 10, 0, 0);
    @(negedge clk); chk("rstmul.stall1", 32'(hz.stall), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk); chk("rstmul.stall2", 32'(hz.stall), 32'd1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("rstmul.after", 0, 1, 0, 0, 0, 0, 0);
    chk("rstmul.perf", 32'(hz.perf_stall), 32'd0);
    next_cycle();

    // Reset at the same edge as a flush: no shadow squash afterwards.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk); chk("rstfl.squash_now", 32'(hz.squash), 32'd1);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rstfl.squash_after", 32'(hz.squash), 32'd0);
    next_cycle();

    // Stall counter saturation: each mul + consumer pair costs two stall cycles.
    for (int it = 0; it < 9; it++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 6, 2, 0);
      next_cycle();
      drive(1, 6, 0, 1, 0, 0, 1, 10, 0, 0);
      repeat (3) next_cycle();
      if (it == 6) chk("sat.perf14", 32'(hz.perf_stall), 32'd14);
    end
    chk("sat.perf_max", 32'(hz.perf_stall), 32'(PMAX));

    // Random traffic against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    next_cycle();
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      int v, rs, rt, urs, urt, late, wreg, rd, cls, fl, rn;
      v    = ($urandom_range(0, 99) < 85) ? 1 : 0;
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      urs  = $urandom_range(0, 1);
      urt  = $urandom_range(0, 1);
      late = urt & $urandom_range(0, 1);
      wreg = $urandom_range(0, 1);
      rd   = $urandom_range(0, 7);
      cls  = $urandom_range(0, 3);
      fl   = ($urandom_range(0, 99) < 8) ? 1 : 0;
      rn   = ($urandom_range(0, 63) == 0) ? 0 : 1;
      drive(v, rs, rt, urs, urt, late, wreg, rd, cls, fl);
      rst_n = 1'(rn);
      @(negedge clk);
      model_eval(v, rs, rt, urs, urt, late, cls, fl);
      chk_outs($sformatf("rnd%0d", c), e_s, e_i, e_sq, e_fa, e_fb, e_lb, e_ls);
      chk($sformatf("rnd%0d.perf", c), 32'(hz.perf_stall), 32'(perf_m));
      @(posedge clk);
      model_commit(rn, wreg, rd, cls, fl);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
